// File: rtl/capture_seq_ctrl.sv
// Capture sequencer: writes cfg_len samples from one ADC lane into capture memory,
// then reads them back in order as fixed-length packets with SOP/EOP marks.
module capture_seq_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int PKT_LEN = 64,
   parameter int LANES   = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_start,
   input  logic              cfg_abort,
   input  logic [3:0]        cfg_lane,
   input  logic [ADDR_W:0]   cfg_len,
   input  logic              adc_vld,
   output logic [3:0]        lane_sel,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              pkt_rdy,
   output logic              pkt_vld,
   output logic              pkt_sop,
   output logic              pkt_eop,
   output logic              busy,
   output logic              done,
   output logic              err_cfg
);

   localparam int              PW       = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
   localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [PW-1:0]   POS_LAST = PW'(PKT_LEN - 1);
   localparam logic [4:0]      LANES_W  = 5'(LANES);

   typedef enum logic [1:0] {IDLE, CAPT, DRAIN, FLUSH} state_t;

   state_t            r_state;
   logic [3:0]        r_lane;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   r_wr_cnt;
   logic [ADDR_W:0]   r_rd_cnt;
   logic [PW-1:0]     r_pos;
   logic              r_pkt_vld;
   logic              r_pkt_sop;
   logic              r_pkt_eop;
   logic              r_done;
   logic              r_err_cfg;

   logic              w_cfg_ok;
   logic              w_wr_last;
   logic              w_rd_last;
   logic              w_wr_en;
   logic              w_rd_en;

   assign w_cfg_ok  = ({1'b0, cfg_lane} < LANES_W) && (cfg_len != '0) && (cfg_len <= DEPTH);
   assign w_wr_last = (r_wr_cnt == r_len - ONE);
   assign w_rd_last = (r_rd_cnt == r_len - ONE);

   // Strobes are combinational so the sample/ready presented this cycle is acted on
   // this cycle; abort suppresses them immediately.
   assign w_wr_en = (r_state == CAPT)  && adc_vld && !cfg_abort;
   assign w_rd_en = (r_state == DRAIN) && pkt_rdy && !cfg_abort;

   // NOTE: all state below uses non-blocking assignments so every register samples
   // the pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_lane    <= '0;
         r_len     <= '0;
         r_wr_cnt  <= '0;
         r_rd_cnt  <= '0;
         r_pos     <= '0;
         r_pkt_vld <= 1'b0;
         r_pkt_sop <= 1'b0;
         r_pkt_eop <= 1'b0;
         r_done    <= 1'b0;
         r_err_cfg <= 1'b0;
      end else begin
         r_pkt_vld <= 1'b0;
         r_pkt_sop <= 1'b0;
         r_pkt_eop <= 1'b0;
         r_done    <= 1'b0;
         if (cfg_abort) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (cfg_start) begin
                     if (w_cfg_ok) begin
                        r_lane    <= cfg_lane;
                        r_len     <= cfg_len;
                        r_wr_cnt  <= '0;
                        r_rd_cnt  <= '0;
                        r_pos     <= '0;
                        r_err_cfg <= 1'b0;
                        r_state   <= CAPT;
                     end else begin
                        r_err_cfg <= 1'b1;
                     end
                  end
               end
               CAPT: begin
                  if (adc_vld) begin
                     r_wr_cnt <= r_wr_cnt + ONE;
                     if (w_wr_last) r_state <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (pkt_rdy) begin
                     r_pkt_vld <= 1'b1;
                     r_pkt_sop <= (r_pos == '0);
                     r_pkt_eop <= (r_pos == POS_LAST) || w_rd_last;
                     r_rd_cnt  <= r_rd_cnt + ONE;
                     r_pos     <= (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
                     if (w_rd_last) begin
                        r_done  <= 1'b1;
                        r_state <= FLUSH;
                     end
                  end
               end
               FLUSH:   r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign lane_sel    = r_lane;
   assign mem_wr_en   = w_wr_en;
   assign mem_wr_addr = r_wr_cnt[ADDR_W-1:0];
   assign mem_rd_en   = w_rd_en;
   assign mem_rd_addr = r_rd_cnt[ADDR_W-1:0];
   assign pkt_vld     = r_pkt_vld;
   assign pkt_sop     = r_pkt_sop;
   assign pkt_eop     = r_pkt_eop;
   assign busy        = (r_state != IDLE);
   assign done        = r_done;
   assign err_cfg     = r_err_cfg;

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Scoreboard bench for capture_seq_ctrl: expected packet words are queued at start
// and popped as pkt_vld words appear; write/read address order is tracked alongside.
module tb_capture_seq_ctrl;

   localparam int ADDR_W  = 10;
   localparam int PKT_LEN = 64;
   localparam int DEPTH   = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_start, cfg_abort, adc_vld, pkt_rdy;
   logic [3:0]        cfg_lane;
   logic [ADDR_W:0]   cfg_len;
   logic [3:0]        lane_sel;
   logic              mem_wr_en, mem_rd_en, pkt_vld, pkt_sop, pkt_eop, busy, done, err_cfg;
   logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;

   capture_seq_ctrl #(.ADDR_W(ADDR_W), .PKT_LEN(PKT_LEN), .LANES(9)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
      .cfg_lane(cfg_lane), .cfg_len(cfg_len), .adc_vld(adc_vld), .lane_sel(lane_sel),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_rd_en(mem_rd_en),
      .mem_rd_addr(mem_rd_addr), .pkt_rdy(pkt_rdy), .pkt_vld(pkt_vld), .pkt_sop(pkt_sop),
      .pkt_eop(pkt_eop), .busy(busy), .done(done), .err_cfg(err_cfg)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic sop; logic eop; logic last;} exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   mon_active = 0;
   int   run_len, wr_idx, rd_idx, done_cnt, sop_cnt;
   bit   prev_rd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic monitor();
      bit   capt_done;
      exp_t e;
      if (!mon_active) return;
      capt_done = (wr_idx == run_len);
      if (adc_vld || mem_wr_en) begin
         check("wr_en", 32'(mem_wr_en), 32'(wr_idx < run_len));
         if (mem_wr_en) begin
            check("wr_addr", 32'(mem_wr_addr), 32'(wr_idx % DEPTH));
            wr_idx++;
         end
      end
      if (pkt_rdy || mem_rd_en) begin
         check("rd_en", 32'(mem_rd_en), 32'(capt_done && rd_idx < run_len));
         if (mem_rd_en) begin
            check("rd_addr", 32'(mem_rd_addr), 32'(rd_idx));
            rd_idx++;
         end
      end
      if (pkt_vld || prev_rd) check("vld_latency", 32'(pkt_vld), 32'(prev_rd));
      if (pkt_vld) begin
         if (q.size() == 0) begin
            check("extra_word", 32'(1), 32'(0));
         end else begin
            e = q.pop_front();
            check("sop", 32'(pkt_sop), 32'(e.sop));
            check("eop", 32'(pkt_eop), 32'(e.eop));
            check("done", 32'(done), 32'(e.last));
         end
      end else if (done) begin
         check("done_no_vld", 32'(done), 32'(0));
      end
      if (done) done_cnt++;
      if (pkt_vld && pkt_sop) sop_cnt++;
      prev_rd = mem_rd_en;
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   // vmode: 0 adc_vld always, 1 toggling. rmode: 0 pkt_rdy always, 1 pattern 1,0,0,1.
   // abort_wr/abort_rd: abort once that many words were written/issued (0 = never).
   task automatic run(input int lane, input int len, input int vmode, input int rmode,
                      input int abort_wr, input int abort_rd);
      int cyc;
      q.delete();
      for (int k = 0; k < len; k++)
         q.push_back('{sop: (k % PKT_LEN == 0),
                       eop: (k % PKT_LEN == PKT_LEN - 1) || (k == len - 1),
                       last: (k == len - 1)});
      run_len = len; wr_idx = 0; rd_idx = 0; done_cnt = 0; sop_cnt = 0; prev_rd = 0;
      cfg_lane = 4'(lane); cfg_len = (ADDR_W+1)'(len); cfg_start = 1'b1;
      mon_active = 1;
      step();
      cfg_start = 1'b0;
      cfg_lane  = 4'hF;
      check("busy_start", 32'(busy), 32'(1));
      check("err_cleared", 32'(err_cfg), 32'(0));
      check("lane_sel", 32'(lane_sel), 32'(lane));
      cyc = 0;
      while (done_cnt == 0 && cyc < 8000) begin
         if ((abort_wr != 0 && wr_idx >= abort_wr) || (abort_rd != 0 && rd_idx >= abort_rd)) begin
            mon_active = 0;
            cfg_abort = 1'b1; adc_vld = 1'b1; pkt_rdy = 1'b1;
            step();
            cfg_abort = 1'b0;
            @(negedge clk);
            check("abort_busy", 32'(busy), 32'(0));
            check("abort_wr_en", 32'(mem_wr_en), 32'(0));
            check("abort_rd_en", 32'(mem_rd_en), 32'(0));
            check("abort_vld", 32'(pkt_vld), 32'(0));
            check("abort_done", 32'(done), 32'(0));
            @(posedge clk);
            #1;
            adc_vld = 1'b0; pkt_rdy = 1'b0;
            check("abort_no_done", 32'(done_cnt), 32'(0));
            return;
         end
         cfg_start = (cyc == 2);
         if (cyc == 2) cfg_len = (ADDR_W+1)'(3);
         adc_vld = (vmode == 0) ? 1'b1 : (cyc % 2 == 0);
         pkt_rdy = (rmode == 0) ? 1'b1 : (cyc % 4 == 0 || cyc % 4 == 3);
         step();
         cyc++;
      end
      cfg_start = 1'b0; adc_vld = 1'b0; pkt_rdy = 1'b0;
      mon_active = 0;
      check("done_count", 32'(done_cnt), 32'(1));
      check("busy_end", 32'(busy), 32'(0));
      check("writes", 32'(wr_idx), 32'(len));
      check("reads", 32'(rd_idx), 32'(len));
      check("q_empty", 32'(q.size()), 32'(0));
      check("packets", 32'(sop_cnt), 32'((len + PKT_LEN - 1) / PKT_LEN));
      check("wr_addr_end", 32'(mem_wr_addr), 32'(len % DEPTH));
   endtask

   task automatic bad_start(input int lane, input int len);
      cfg_lane = 4'(lane); cfg_len = (ADDR_W+1)'(len); cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      check("err_set", 32'(err_cfg), 32'(1));
      check("err_busy", 32'(busy), 32'(0));
   endtask

   initial begin
      rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; adc_vld = 1'b0; pkt_rdy = 1'b0;
      cfg_lane = '0; cfg_len = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {20'd0, lane_sel, mem_wr_en, mem_rd_en, pkt_vld, pkt_sop,
                            pkt_eop, busy, done, err_cfg}, 32'd0);
      check("rst_addrs", {12'd0, mem_wr_addr, mem_rd_addr}, 32'd0);
      rst_n = 1'b1;
      step();

      run(3, 5, 0, 0, 0, 0);
      run(1, 130, 0, 0, 0, 0);
      run(8, DEPTH, 1, 0, 0, 0);
      run(2, 70, 0, 1, 0, 0);
      run(0, 1, 0, 0, 0, 0);

      bad_start(9, 5);
      step();
      check("err_sticky", 32'(err_cfg), 32'(1));
      bad_start(0, 0);
      bad_start(4, DEPTH + 1);
      run(5, 4, 0, 0, 0, 0);

      run(6, 20, 0, 0, 8, 0);
      run(6, 10, 0, 0, 0, 4);
      run(7, 12, 1, 1, 0, 0);

      cfg_lane = 4'd4; cfg_len = (ADDR_W+1)'(50); cfg_start = 1'b1;
      step();
      cfg_start = 1'b0; adc_vld = 1'b1;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; adc_vld = 1'b0;
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_state", {22'd0, lane_sel, mem_wr_addr[3:0], mem_wr_en, done}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
